// File: rtl/pwm_duty_pkg.sv
// Shared types and elaboration-time constants for the PWM duty decoder.
package pwm_duty_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_DONE
  } t_div_state;

  localparam int c_sync_stages = 2;

  function automatic int unsigned calc_period(input int unsigned fclk,
                                              input int unsigned period_ms);
    return fclk / 1000 * period_ms;
  endfunction

  // Clock cycles of high time per palette step.
  function automatic int unsigned calc_r(input int unsigned period,
                                         input int unsigned tenths);
    return (period / 10 * tenths) / 256;
  endfunction

endpackage

// File: rtl/pwm_duty_divider.sv
// Per-channel 8-step restoring divider: high_count / R, saturating to 255.
// A force input lets the timeout path overwrite the reported value directly.
module pwm_duty_divider
  import pwm_duty_pkg::*;
#(
  parameter int unsigned parm_divisor = 9
) (
  input  logic        i_clk,
  input  logic        i_srst,
  input  logic        req_i,
  input  logic [31:0] dividend_i,
  input  logic        force_i,
  input  logic [7:0]  force_value_i,
  output logic [7:0]  result_o,
  output logic        done_o,
  output logic        last_step_o
);

  localparam logic [31:0] c_div = 32'(parm_divisor);
  localparam logic [31:0] c_sat = 32'(parm_divisor) << 8;

  t_div_state  state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [7:0]  quot_q, quot_d;
  logic [7:0]  result_q, result_d;
  logic [2:0]  step_q, step_d;
  logic        sat_q, sat_d;
  logic [31:0] trial;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    result_d = result_q;
    step_d   = step_q;
    sat_d    = sat_q;
    trial    = c_div << step_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        rem_d   = dividend_i;
        sat_d   = (dividend_i >= c_sat);
        quot_d  = '0;
        step_d  = 3'd7;
        state_d = ST_DIV;
      end
      ST_DIV: begin
        if (rem_q >= trial) begin
          rem_d          = rem_q - trial;
          quot_d[step_q] = 1'b1;
        end
        step_d = step_q - 3'd1;
        // Result register moves on the final step so it is valid during ST_DONE.
        if (step_q == 3'd0) begin
          result_d = sat_q ? 8'hFF : quot_d;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (force_i) result_d = force_value_i;
  end

  always_ff @(posedge i_clk or posedge i_srst) begin
    if (i_srst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
      step_q   <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      result_q <= result_d;
      step_q   <= step_d;
      sat_q    <= sat_d;
    end
  end

  assign result_o    = result_q;
  assign done_o      = (state_q == ST_DONE);
  assign last_step_o = (state_q == ST_DIV) && (step_q == 3'd0);

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers palette values from N PWM inputs by measuring high time per period.
// Optional period-window check is built when PWM_DUTY_PERIOD_CHECK_EN is defined.
module pwm_duty_decoder
  import pwm_duty_pkg::*;
#(
  parameter int unsigned parm_channel_count           = 4,
  parameter int unsigned parm_FCLK                    = 40_000_000,
  parameter int unsigned parm_pwm_period_milliseconds = 10,
  parameter int unsigned parm_max_duty_tenths         = 5
) (
  input  logic                            i_clk,
  input  logic                            i_srst,
  input  logic [parm_channel_count-1:0]   ei_pwm,
  output logic [8*parm_channel_count-1:0] o_value,
  output logic [parm_channel_count-1:0]   o_valid,
  output logic [parm_channel_count-1:0]   o_timeout,
  output logic [parm_channel_count-1:0]   o_period_error
);

  localparam int unsigned c_p   = calc_period(parm_FCLK, parm_pwm_period_milliseconds);
  localparam int unsigned c_r   = calc_r(c_p, parm_max_duty_tenths);
  localparam logic [31:0] c_p2  = 32'(2 * c_p);

  if (c_r < 2) begin : g_bad_ratio
    $error("pwm_duty_decoder: cycles per palette step must be at least 2");
  end

  for (genvar k = 0; k < parm_channel_count; k++) begin : g_ch
    logic [c_sync_stages-1:0] sync_q;
    logic        level_q;
    logic        rise_q;
    logic [31:0] period_q, period_d;
    logic [31:0] high_q, high_d;
    logic [31:0] high_lat_q;
    logic        armed_q;
    logic        req_q;
    logic        timeout_q;
    logic        tmo_valid_q;
    logic        tmo_evt;
    logic        div_done;
    logic        div_last;
    logic [7:0]  div_result;

    always_ff @(posedge i_clk or posedge i_srst) begin
      if (i_srst) begin
        sync_q  <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
      end else begin
        sync_q  <= {sync_q[c_sync_stages-2:0], ei_pwm[k]};
        level_q <= sync_q[c_sync_stages-1];
        rise_q  <= sync_q[c_sync_stages-1] & ~level_q;
      end
    end

    // A rise in the same cycle as the terminal count suppresses the timeout.
    assign tmo_evt = ~rise_q && (period_q == c_p2 - 32'd1);

    always_comb begin
      period_d = period_q;
      high_d   = high_q;
      if (rise_q) begin
        period_d = 32'd1;
        high_d   = 32'd1;
      end else begin
        if (period_q != c_p2) period_d = period_q + 32'd1;
        if (level_q && (high_q != c_p2)) high_d = high_q + 32'd1;
      end
    end

    always_ff @(posedge i_clk or posedge i_srst) begin
      if (i_srst) begin
        period_q    <= '0;
        high_q      <= '0;
        high_lat_q  <= '0;
        armed_q     <= 1'b0;
        req_q       <= 1'b0;
        timeout_q   <= 1'b0;
        tmo_valid_q <= 1'b0;
      end else begin
        period_q    <= period_d;
        high_q      <= high_d;
        req_q       <= rise_q & armed_q;
        tmo_valid_q <= tmo_evt;
        if (rise_q) begin
          high_lat_q <= high_q;
          armed_q    <= 1'b1;
          timeout_q  <= 1'b0;
        end else if (tmo_evt) begin
          armed_q   <= 1'b0;
          timeout_q <= 1'b1;
        end
      end
    end

    pwm_duty_divider #(
      .parm_divisor (c_r)
    ) u_div (
      .i_clk         (i_clk),
      .i_srst        (i_srst),
      .req_i         (req_q),
      .dividend_i    (high_lat_q),
      .force_i       (tmo_evt),
      .force_value_i (level_q ? 8'hFF : 8'h00),
      .result_o      (div_result),
      .done_o        (div_done),
      .last_step_o   (div_last)
    );

    assign o_value[8*k +: 8] = div_result;
    assign o_valid[k]        = div_done | tmo_valid_q;
    assign o_timeout[k]      = timeout_q;

`ifdef PWM_DUTY_PERIOD_CHECK_EN
    localparam logic [31:0] c_p_lo = 32'(c_p - 1);
    localparam logic [31:0] c_p_hi = 32'(c_p + 1);
    logic perr_pend_q;
    logic perr_q;

    // Flag is captured at the rise but published alongside the value it belongs to.
    always_ff @(posedge i_clk or posedge i_srst) begin
      if (i_srst) begin
        perr_pend_q <= 1'b0;
        perr_q      <= 1'b0;
      end else begin
        if (rise_q && armed_q) perr_pend_q <= (period_q < c_p_lo) || (period_q > c_p_hi);
        if (div_last) perr_q <= perr_pend_q;
      end
    end

    assign o_period_error[k] = perr_q;
`else
    logic unused_last;
    assign unused_last       = div_last;
    assign o_period_error[k] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: P = 2560, R = 9, four channels.
`timescale 1ns/1ps
module tb_pwm_duty_decoder;

  localparam int NCH     = 4;
  localparam int P       = 2560;
  localparam int VAL_LAT = 14;          // drive edge -> o_valid (3 front end + 11)
  localparam int TMO_LAT = 3 + 2 * P;   // last driven rise -> timeout strobe
`ifdef PWM_DUTY_PERIOD_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  typedef struct {
    logic [7:0] val;
    logic       to;
    logic       pe;
    int         at;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwm_drv [NCH];
  logic [NCH-1:0]   pwm;
  logic [8*NCH-1:0] value;
  logic [NCH-1:0]   valid;
  logic [NCH-1:0]   timeout;
  logic [NCH-1:0]   perr;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   bg_run = 1'b1;
  exp_t sb [NCH][$];
  logic [7:0] last_val [NCH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    pwm = '0;
    for (int k = 0; k < NCH; k++) pwm[k] = pwm_drv[k];
  end

  pwm_duty_decoder #(
    .parm_channel_count           (NCH),
    .parm_FCLK                    (2_560_000),
    .parm_pwm_period_milliseconds (1),
    .parm_max_duty_tenths         (9)
  ) dut (
    .i_clk          (clk),
    .i_srst         (rst),
    .ei_pwm         (pwm),
    .o_value        (value),
    .o_valid        (valid),
    .o_timeout      (timeout),
    .o_period_error (perr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_rise(input int k, input bit report, input logic [7:0] v, input logic pe);
    pwm_drv[k] = 1'b1;
    if (report) sb[k].push_back('{val: v, to: 1'b0, pe: pe, at: cyc + VAL_LAT});
  endtask

  task automatic period(input int k, input int high, input int per);
    hold(high);
    pwm_drv[k] = 1'b0;
    hold(per - high);
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int k = 0; k < NCH; k++) if (sb[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain();
    for (int w = 0; w < 10000 && !all_empty(); w++) hold(1);
    for (int k = 0; k < NCH; k++) chk($sformatf("drained ch%0d", k), sb[k].size(), 0);
  endtask

  // Channel 0: value 100, low-end and saturation points, period error, timeouts.
  task automatic ch0_seq();
    int   t_high [9] = '{900, 900, 1, 2303, 2304, 2559, 5, 900, 900};
    int   t_per  [9] = '{2560, 2560, 2560, 2560, 2560, 2560, 2560, 2600, 2560};
    int   t_val  [9] = '{100, 100, 0, 255, 255, 255, 0, 100, 100};
    bit   t_bad  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    int   r;
    drive_rise(0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      period(0, t_high[i], t_per[i]);
      drive_rise(0, 1'b1, 8'(t_val[i]), PCHK & t_bad[i]);
    end
    // Line stuck high: timeout reports 255 once.
    r = cyc;
    sb[0].push_back('{val: 8'd255, to: 1'b1, pe: 1'b0, at: r + TMO_LAT});
    hold(TMO_LAT + 50);
    pwm_drv[0] = 1'b0;
    hold(100);
    chk("timeout held ch0", timeout[0], 1);
    drive_rise(0, 1'b0, 8'd0, 1'b0);
    hold(5);
    chk("timeout cleared by rise ch0", timeout[0], 0);
    period(0, 895, P);
    drive_rise(0, 1'b1, 8'd100, 1'b0);
    // Line stuck low: timeout reports 0.
    r = cyc;
    sb[0].push_back('{val: 8'd0, to: 1'b1, pe: 1'b0, at: r + TMO_LAT});
    hold(900);
    pwm_drv[0] = 1'b0;
    hold(TMO_LAT);
  endtask

  task automatic bg(input int k, input int high, input logic [7:0] v, input int offset);
    bit first = 1'b1;
    int r = 0;
    hold(offset);
    while (bg_run) begin
      drive_rise(k, !first, v, 1'b0);
      r = cyc;
      first = 1'b0;
      period(k, high, P);
    end
    sb[k].push_back('{val: 8'd0, to: 1'b1, pe: 1'b0, at: r + TMO_LAT});
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      for (int k = 0; k < NCH; k++) last_val[k] = 8'd0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (valid[k]) begin
          if (sb[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected valid ch%0d: got value %0d, expected no strobe (cycle %0d)",
                     k, value[8*k +: 8], cyc);
          end else begin
            e = sb[k].pop_front();
            chk($sformatf("value ch%0d", k), value[8*k +: 8], e.val);
            chk($sformatf("valid cycle ch%0d", k), cyc, e.at);
            chk($sformatf("timeout ch%0d", k), timeout[k], e.to);
            chk($sformatf("period_error ch%0d", k), perr[k], e.pe);
            last_val[k] = e.val;
          end
        end else if (cyc % 16 == 0) begin
          chk($sformatf("value hold ch%0d", k), value[8*k +: 8], last_val[k]);
        end
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    for (int k = 0; k < NCH; k++) pwm_drv[k] = 1'b0;
    hold(3);
    chk("reset value", value, 0);
    chk("reset valid", valid, 0);
    chk("reset timeout", timeout, 0);
    chk("reset period_error", perr, 0);
    rst = 1'b0;
    hold(10);

    fork
      begin
        ch0_seq();
        bg_run = 1'b0;
      end
      bg(1, 337, 8'd37, 200);
      bg(2, 1155, 8'd128, 700);
      bg(3, 2295, 8'd255, 1300);
    join
    drain();
    chk("all timed out", timeout, 4'hF);

    // Reset in the middle of a divide.
    drive_rise(0, 1'b0, 8'd0, 1'b0);
    period(0, 900, P);
    drive_rise(0, 1'b1, 8'd100, 1'b0);
    period(0, 5, P);
    drive_rise(0, 1'b0, 8'd0, 1'b0);
    hold(5);
    pwm_drv[0] = 1'b0;
    hold(4);
    rst = 1'b1;
    #1;
    chk("mid-divide reset value", value, 0);
    chk("mid-divide reset valid", valid, 0);
    chk("mid-divide reset timeout", timeout, 0);
    chk("mid-divide reset period_error", perr, 0);
    hold(3);
    rst = 1'b0;
    m = cyc;
    for (int k = 1; k < NCH; k++)
      sb[k].push_back('{val: 8'd0, to: 1'b1, pe: 1'b0, at: m + 2 * P});
    hold(P);
    drive_rise(0, 1'b0, 8'd0, 1'b0);
    period(0, 900, P);
    drive_rise(0, 1'b1, 8'd100, 1'b0);
    hold(20);
    pwm_drv[0] = 1'b0;
    drain();
    hold(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_duty_decoder.md
# pwm_duty_decoder

Measures the duty cycle of N incoming single-emitter PWM waveforms and recovers the 8-bit palette value that produced each one, the inverse of the LED PWM palette driver. It is used in loopback self-test, where driver outputs are routed back through FPGA pins, and by the verification bench as a scoreboard front end. Each channel reports one recovered value per PWM period, plus a stuck-line timeout and an optional period-error flag.

## Interface
- parm_channel_count, 4, number of PWM inputs decoded.
- parm_FCLK, 40_000_000, clock frequency in Hz.
- parm_pwm_period_milliseconds, 10, nominal PWM period.
- parm_max_duty_tenths, 5, full-scale duty in tenths of the period. Use 5 for color emitters, 9 for basic emitters.
- i_clk, in, 1, clock.
- i_srst, in, 1, reset; asynchronous, active-high.
- ei_pwm, in, parm_channel_count, asynchronous PWM inputs.
- o_value, out, 8*parm_channel_count, recovered value; channel k occupies bits [8k+7:8k].
- o_valid, out, parm_channel_count, one-cycle strobe per channel when o_value slice updates.
- o_timeout, out, parm_channel_count, level; the channel has seen no rising edge for 2 periods.
- o_period_error, out, parm_channel_count, level; the last measured period was out of window.

## Operation
- Constants:
  - P = parm_FCLK/1000*parm_pwm_period_milliseconds.
  - R = (P/10*parm_max_duty_tenths)/256, integer division throughout.
  - R must be ≥ 2; violating this is an elaboration error.
- Per channel front end:
  - 2-flop synchronizer, then an edge register; rise = sync & ~prev.
  - Period counter and high counter, each 32-bit and saturating at 2P.
  - The high counter increments on every cycle the synchronized level is 1.
- On rise:
  - Latch high_count and period_count, then clear both counters; the rise cycle counts as cycle 1 of the new period.
  - The first rise after reset or after a timeout only arms the channel. It produces no o_valid.
  - On later rises, issue a divide request for the latched high_count.
- Divide, per-channel sub-module:
  - If high_count ≥ 256*R, the result is 255.
  - Otherwise the result is floor(high_count/R) via 8-step restoring division.
  - The driver's output for value v has a high time in [v*R, v*R+R-1], so decoding is exact.
- Divider FSM, states ST_IDLE → ST_LOAD → ST_DIV (8 cycles) → ST_DONE → ST_IDLE:
  - ST_DONE writes o_value and pulses o_valid.
  - A rise arriving while the FSM is busy is ignored (cannot occur at legal periods).
- Timeout:
  - When the period counter reaches 2P without a rise, set o_timeout.
  - o_value = 255 if the synchronized level is 1, else 0; pulse o_valid once.
  - The channel disarms. The next rise clears o_timeout and re-arms the channel.
- Reset values: o_value = 0, o_valid = 0, o_timeout = 0, o_period_error = 0. All counters clear and all channels disarm. Reset asserted mid-divide aborts the divide immediately.

## Timing
- Input edge to rise: 3 clocks (2 sync + edge register).
- Rise to o_valid: 11 clocks (1 latch, 1 load, 8 divide, 1 done).
- o_value slice is stable from the o_valid cycle until the next o_valid.
- Simultaneous rise and timeout in the same cycle: the rise wins and no timeout is flagged.

## Configuration
- PWM_DUTY_PERIOD_CHECK_EN:
  - Defined: on each measured rise, o_period_error = (period_count < P-1 or period_count > P+1). The flag updates in the same cycle as o_valid, and the value is still reported.
  - Undefined: o_period_error is tied 0 and no comparator logic is built.
  - The timeout logic is present in both cases.

## Structure
- Package pwm_duty_pkg holds:
  - t_div_state enum (ST_IDLE, ST_LOAD, ST_DIV, ST_DONE).
  - Functions for P and R.
  - c_sync_stages = 2.
- Sub-module pwm_duty_divider: one 32-bit/R restoring divider with saturation, req/done handshake, instantiated per channel in a generate loop.

## Test plan
All scenarios use parm_FCLK = 2_560_000, 1 ms period, tenths = 9, giving P = 2560 and R = 9.
- Drive value 100 as high 900 of 2560 cycles, repeated:
  - 1st rise gives no valid.
  - Each later rise gives o_valid after 11 cycles with value 100.
  - o_period_error stays 0.
- Drive high times 0, 1, 2303, 2304 and 2559 cycles → values 0, 0, 255, 255, 255 (saturation).
- Hold input at 1 → after 5120 cycles o_timeout = 1, value = 255, one o_valid. Resume normal input → first rise clears o_timeout, and the next rise reports the value.
- With the macro defined, use a 2600-cycle period → o_period_error = 1 with a valid value. Return to 2560 → the flag clears on the next valid.
- Run 4 channels with values 0, 37, 128 and 255 at staggered phases → each slice is correct and independent.
- Assert reset mid-divide → all outputs are 0 immediately. After release, the first rise produces no valid.
